// File: rtl/gate_pkg.sv
// Shared gate state encoding for the gate automata modules.
package gate_pkg;

  typedef enum logic [1:0] {
    OPENED = 2'b00,
    CLOSED = 2'b01,
    PAYED  = 2'b10
  } gate_state_t;

endpackage

// File: rtl/gate_rr_arbiter.sv
// Round-robin arbiter over payment terminals: combinational one-hot grant,
// registered search pointer that moves just past the last winner.
module gate_rr_arbiter #(
  parameter int N_TERM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_TERM-1:0] req,
  input  logic [N_TERM-1:0] mask,
  output logic [N_TERM-1:0] grant
);

  localparam int PTR_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;

  logic [PTR_W-1:0]  ptr_reg;
  logic [PTR_W-1:0]  ptr_next;
  logic [N_TERM-1:0] eligible;
  logic              found;
  int                idx;

  // A terminal acked last cycle still holds its request this cycle; mask it.
  assign eligible = req & ~mask;

  always_comb begin
    grant    = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < N_TERM; off++) begin
      idx = int'(ptr_reg) + off;
      if (idx >= N_TERM) idx = idx - N_TERM;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = (idx == N_TERM - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/gate_sequencer.sv
// Turnstile sequencer: arbitrates payments, banks credit, drives the gate FSM.
// Optional auto-close of an open gate is compiled in with GATE_TIMEOUT_EN.
module gate_sequencer
  import gate_pkg::*;
#(
  parameter int N_TERM      = 4,
  parameter int CREDIT_MAX  = 15,
  parameter int TIMEOUT_CYC = 1000,
  localparam int CREDIT_W   = $clog2(CREDIT_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_TERM-1:0]   pay_req,
  output logic [N_TERM-1:0]   pay_ack,
  input  logic                turn_i,
  output logic [1:0]          state_o,
  output logic                unlock_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                overflow_o,
  output logic                timeout_o
);

  localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_MAX);

  logic [N_TERM-1:0] grant;
  logic              granted;
  logic              consume;
  gate_state_t       state_reg;

  gate_rr_arbiter #(.N_TERM(N_TERM)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (pay_req),
    .mask  (pay_ack),
    .grant (grant)
  );

  assign granted = |grant;
  assign consume = (state_reg == CLOSED) && (credit_o != '0);
  assign state_o = state_reg;

  // A payment granted while the gate consumes still counts for the next pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pay_ack    <= '0;
      credit_o   <= '0;
      overflow_o <= 1'b0;
    end else begin
      pay_ack    <= grant;
      overflow_o <= granted && !consume && (credit_o == CREDIT_FULL);
      if (granted && !consume) begin
        if (credit_o != CREDIT_FULL) credit_o <= credit_o + 1'b1;
      end else if (!granted && consume) begin
        credit_o <= credit_o - 1'b1;
      end
    end
  end

`ifdef GATE_TIMEOUT_EN
  localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  logic [TIMER_W-1:0] timer_reg;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC < 2);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= CLOSED;
      unlock_o  <= 1'b0;
      timeout_o <= 1'b0;
`ifdef GATE_TIMEOUT_EN
      timer_reg <= '0;
`endif
    end else begin
      timeout_o <= 1'b0;
      case (state_reg)
        CLOSED: begin
          if (credit_o != '0) begin
            state_reg <= PAYED;
            unlock_o  <= 1'b1;
          end
        end
        PAYED: begin
          if (turn_i) begin
            state_reg <= OPENED;
            unlock_o  <= 1'b0;
`ifdef GATE_TIMEOUT_EN
            timer_reg <= '0;
`endif
          end
        end
        OPENED: begin
          // A rotation on the timeout edge closes normally, without timeout_o.
          if (turn_i) begin
            state_reg <= CLOSED;
          end
`ifdef GATE_TIMEOUT_EN
          else if (timer_reg == TIMER_LAST) begin
            state_reg <= CLOSED;
            timeout_o <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
`endif
        end
        default: begin
          state_reg <= CLOSED;
          unlock_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer; ack/overflow events checked by a scoreboard monitor.
module tb_gate_sequencer;

  localparam int N_TERM = 4;
  localparam int CW     = 4;

  logic              clk;
  logic              rst_n;
  logic [N_TERM-1:0] pay_req;
  logic [N_TERM-1:0] pay_ack;
  logic              turn_i;
  logic [1:0]        state_o;
  logic              unlock_o;
  logic [CW-1:0]     credit_o;
  logic              overflow_o;
  logic              timeout_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N_TERM-1:0] ack;
    logic              ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  gate_sequencer #(
    .N_TERM      (N_TERM),
    .CREDIT_MAX  (15),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pay_req    (pay_req),
    .pay_ack    (pay_ack),
    .turn_i     (turn_i),
    .state_o    (state_o),
    .unlock_o   (unlock_o),
    .credit_o   (credit_o),
    .overflow_o (overflow_o),
    .timeout_o  (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic push(input logic [N_TERM-1:0] a, input logic o);
    exp_t e;
    e.ack = a;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic turn_pulse();
    turn_i = 1'b1;
    step();
    turn_i = 1'b0;
  endtask

  // Monitor: every ack/overflow event the DUT presents must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && (pay_ack != '0 || overflow_o)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=%b ovf=%b, required no event", pay_ack, overflow_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_ack", 32'(pay_ack), 32'(mon_e.ack));
        chk("sb_ovf", 32'(overflow_o), 32'(mon_e.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    pay_req = '0;
    turn_i  = 1'b0;
    step();
    step();
    chk("rst_state", 32'(state_o), 32'h1);
    chk("rst_credit", 32'(credit_o), 32'h0);
    chk("rst_unlock", 32'(unlock_o), 32'h0);
    chk("rst_ack", 32'(pay_ack), 32'h0);
    chk("rst_ovf", 32'(overflow_o), 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);
    rst_n = 1'b1;

    // Single payment on terminal 2 held across two edges: one ack only.
    pay_req = 4'b0100;
    push(4'b0100, 1'b0);
    step();
    chk("t1_credit_k", 32'(credit_o), 32'h1);
    chk("t1_state_k", 32'(state_o), 32'h1);
    step();
    pay_req = '0;
    chk("t1_credit_k1", 32'(credit_o), 32'h0);
    chk("t1_state_k1", 32'(state_o), 32'h2);
    chk("t1_unlock", 32'(unlock_o), 32'h1);
    step();
    chk("t1_payed_hold", 32'(state_o), 32'h2);

    // Rotations: PAYED -> OPENED -> CLOSED; turn in CLOSED with no credit ignored.
    turn_pulse();
    chk("turn_opened", 32'(state_o), 32'h0);
    chk("turn_unlock0", 32'(unlock_o), 32'h0);
    step();
    chk("opened_hold", 32'(state_o), 32'h0);
    turn_pulse();
    chk("turn_closed", 32'(state_o), 32'h1);
    chk("closed_unlock", 32'(unlock_o), 32'h0);
    turn_pulse();
    chk("closed_turn_state", 32'(state_o), 32'h1);
    chk("closed_turn_credit", 32'(credit_o), 32'h0);

`ifdef GATE_TIMEOUT_EN
    pay_req = 4'b0010;
    push(4'b0010, 1'b0);
    step();
    pay_req = '0;
    step();
    chk("to_payed", 32'(state_o), 32'h2);
    turn_pulse();
    repeat (3) step();
    chk("to_still_open", 32'(state_o), 32'h0);
    chk("to_no_pulse_yet", 32'(timeout_o), 32'h0);
    step();
    chk("to_closed", 32'(state_o), 32'h1);
    chk("to_pulse", 32'(timeout_o), 32'h1);
    step();
    chk("to_pulse_end", 32'(timeout_o), 32'h0);

    pay_req = 4'b0010;
    push(4'b0010, 1'b0);
    step();
    pay_req = '0;
    step();
    turn_pulse();
    repeat (3) step();
    turn_pulse();
    chk("to_turn_wins_state", 32'(state_o), 32'h1);
    chk("to_turn_wins_pulse", 32'(timeout_o), 32'h0);
`else
    pay_req = 4'b0010;
    push(4'b0010, 1'b0);
    step();
    pay_req = '0;
    step();
    turn_pulse();
    repeat (10) step();
    chk("noto_still_open", 32'(state_o), 32'h0);
    chk("noto_pulse", 32'(timeout_o), 32'h0);
    turn_pulse();
    chk("noto_closed", 32'(state_o), 32'h1);
`endif

    // All four terminals held from reset: acks rotate 0,1,2,3,0... until credit saturates.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    pay_req = 4'b1111;
    for (int n = 1; n <= 17; n++) begin
      push(4'(1 << ((n - 1) % 4)), (n == 17));
      step();
      if (n == 1) begin
        chk("rr_credit_e1", 32'(credit_o), 32'h1);
        chk("rr_state_e1", 32'(state_o), 32'h1);
      end
      if (n == 2) begin
        chk("rr_credit_e2", 32'(credit_o), 32'h1);
        chk("rr_state_e2", 32'(state_o), 32'h2);
      end
      if (n == 16) chk("rr_credit_full", 32'(credit_o), 32'hf);
      if (n == 17) begin
        chk("rr_credit_sat", 32'(credit_o), 32'hf);
        chk("rr_ovf", 32'(overflow_o), 32'h1);
      end
    end
    pay_req = '0;
    step();

    pay_req = 4'b0001;
    push(4'b0001, 1'b1);
    step();
    pay_req = '0;
    chk("ovf_ack", 32'(pay_ack), 32'h1);
    chk("ovf_pulse", 32'(overflow_o), 32'h1);
    chk("ovf_credit", 32'(credit_o), 32'hf);
    step();
    chk("ovf_pulse_end", 32'(overflow_o), 32'h0);

    // Asynchronous reset while OPENED with banked credit.
    turn_pulse();
    chk("pre_rst_state", 32'(state_o), 32'h0);
    chk("pre_rst_credit", 32'(credit_o), 32'hf);
    #2;
    rst_n   = 1'b0;
    pay_req = 4'b1001;
    #1;
    chk("async_state", 32'(state_o), 32'h1);
    chk("async_credit", 32'(credit_o), 32'h0);
    chk("async_unlock", 32'(unlock_o), 32'h0);
    step();
    push(4'b0001, 1'b0);
    push(4'b1000, 1'b0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ack0", 32'(pay_ack), 32'h1);
    chk("post_rst_credit", 32'(credit_o), 32'h1);
    step();
    pay_req = '0;
    chk("post_rst_ack3", 32'(pay_ack), 32'h8);
    chk("post_rst_credit2", 32'(credit_o), 32'h1);
    chk("post_rst_state", 32'(state_o), 32'h2);
    step();
    step();

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
